// File: rtl/sigmoid_result_packer_if.sv
// Ready/valid master bus carrying packed sigmoid result words.
//   m_valid : head word valid           (master -> slave)
//   m_ready : consumer accepts head     (slave  -> master)
//   m_data  : LANES packed bf16 lanes, lane k at [16k+15:16k]
//   m_mask  : bit k set when lane k holds a real result
//   m_last  : word was closed by a flush
interface sigmoid_result_packer_if #(
    parameter int LANES = 4
);
    logic                  m_valid;
    logic                  m_ready;
    logic [16*LANES-1:0]   m_data;
    logic [LANES-1:0]      m_mask;
    logic                  m_last;

    modport master (output m_valid, m_data, m_mask, m_last, input m_ready);
    modport slave  (input m_valid, m_data, m_mask, m_last, output m_ready);
endinterface

// File: rtl/sigmoid_result_packer.sv
// Packs the no-backpressure bf16 sigmoid result stream into LANES-wide words,
// buffers them in a DEPTH-word FIFO and presents them on a ready/valid bus.
// A lane-slot credit counter gates upstream issue so results are never lost.
//   clk, rst     : clock, asynchronous active-high reset
//   issue_in     : upstream injected one operand this cycle
//   can_issue    : credits available
//   valid_in     : result valid, data_in : bf16 result
//   flush_in     : close the partially filled word
//   m            : packed word master bus
//   overflow_err : sticky, a result/word was dropped or issue underflowed
module sigmoid_result_packer #(
    parameter int LANES = 4,
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    issue_in,
    output logic                    can_issue,
    input  logic                    valid_in,
    input  logic [15:0]             data_in,
    input  logic                    flush_in,
    output logic                    overflow_err,
    sigmoid_result_packer_if.master m
);
    localparam int LW   = $clog2(LANES);
    localparam int AW   = $clog2(DEPTH);
    localparam int CMAX = DEPTH * LANES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [LW-1:0] LC_MAX = LW'(LANES - 1);

    logic [LW-1:0]              r_lc;
    logic [LANES-1:0][15:0]     r_acc;
    logic [16*LANES-1:0]        r_mem_data [DEPTH];
    logic [LANES-1:0]           r_mem_mask [DEPTH];
    logic                       r_mem_last [DEPTH];
    logic [AW-1:0]              r_wr, r_rd;
    logic [AW:0]                r_cnt;
    logic [CW-1:0]              r_credits;
    logic                       r_ovf;

    logic                       w_pop, w_full, w_fill, w_flush_go;
    logic                       w_commit, w_push, w_drop;
    logic                       w_issue_ok, w_issue_bad;
    logic [LW:0]                w_nfill;
    logic [16*LANES-1:0]        w_word;
    logic [LANES-1:0]           w_mask;
    logic [CW:0]                w_cred_sum;

    assign w_pop      = (r_cnt != '0) && m.m_ready;
    assign w_full     = (r_cnt == (AW+1)'(DEPTH));
    assign w_fill     = valid_in && (r_lc == LC_MAX);
    // lanes filled once a same-cycle result is absorbed
    assign w_nfill    = {1'b0, r_lc} + (LW+1)'(valid_in);
    assign w_flush_go = flush_in && (w_nfill != '0);
    assign w_commit   = w_fill || w_flush_go;
    // a full FIFO still takes a word when its head leaves in the same cycle
    assign w_push     = w_commit && (!w_full || w_pop);
    assign w_drop     = w_commit && !w_push;
    assign w_issue_ok  = issue_in && (r_credits != '0);
    assign w_issue_bad = issue_in && (r_credits == '0);

    // lanes below lc come from the accumulator, lane lc from the live input,
    // everything above is zero so partial words carry no stale data
    always_comb begin
        w_word = '0;
        w_mask = '0;
        for (int i = 0; i < LANES; i++) begin
            if (LW'(i) < r_lc)
                w_word[16*i +: 16] = r_acc[i];
            else if ((LW'(i) == r_lc) && valid_in)
                w_word[16*i +: 16] = data_in;
            w_mask[i] = ((LW+1)'(i) < w_nfill);
        end
    end

    // a flush returns the slots of the lanes it leaves empty; a full word
    // flushed returns nothing since w_nfill == LANES
    always_comb begin
        w_cred_sum = {1'b0, r_credits}
                   + (w_pop ? (CW+1)'(LANES) : '0)
                   + ((w_push && w_flush_go) ? ((CW+1)'(LANES) - (CW+1)'(w_nfill)) : '0)
                   - (CW+1)'(w_issue_ok);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lc      <= '0;
            r_acc     <= '0;
            r_wr      <= '0;
            r_rd      <= '0;
            r_cnt     <= '0;
            r_credits <= CW'(CMAX);
            r_ovf     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_data[i] <= '0;
                r_mem_mask[i] <= '0;
                r_mem_last[i] <= 1'b0;
            end
        end else begin
            if (w_commit)
                r_lc <= '0;
            else if (valid_in) begin
                r_lc        <= r_lc + 1'b1;
                r_acc[r_lc] <= data_in;
            end

            if (w_push) begin
                r_mem_data[r_wr] <= w_word;
                r_mem_mask[r_wr] <= w_mask;
                r_mem_last[r_wr] <= flush_in;
                r_wr             <= r_wr + 1'b1;
            end
            if (w_pop)
                r_rd <= r_rd + 1'b1;
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);

            r_credits <= (w_cred_sum > (CW+1)'(CMAX)) ? CW'(CMAX) : w_cred_sum[CW-1:0];
            r_ovf     <= r_ovf | w_drop | w_issue_bad;
        end
    end

    assign can_issue    = (r_credits != '0);
    assign overflow_err = r_ovf;
    assign m.m_valid    = (r_cnt != '0);
    assign m.m_data     = r_mem_data[r_rd];
    assign m.m_mask     = r_mem_mask[r_rd];
    assign m.m_last     = r_mem_last[r_rd];
endmodule

// File: tb/tb_sigmoid_result_packer.sv
module tb_sigmoid_result_packer;
    localparam int LANES = 4;
    localparam int DEPTH = 8;
    localparam int CMAX  = LANES * DEPTH;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        issue_in = 1'b0, valid_in = 1'b0, flush_in = 1'b0, m_ready = 1'b0;
    logic [15:0] data_in = '0;
    wire         can_issue, overflow_err;

    sigmoid_result_packer_if #(.LANES(LANES)) mif();
    assign mif.m_ready = m_ready;

    sigmoid_result_packer #(.LANES(LANES), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .issue_in(issue_in), .can_issue(can_issue),
        .valid_in(valid_in), .data_in(data_in), .flush_in(flush_in),
        .overflow_err(overflow_err), .m(mif.master)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] d;
        logic [3:0]  k;
        logic        l;
    } word_t;

    int          checks = 0, errors = 0;
    word_t       sb[$];
    logic [15:0] pend[$];
    int          mocc = 0, mcred = CMAX, inflight = 0;
    bit          movf = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // reference model: lane slots, FIFO occupancy and credits advanced per clock edge
    task automatic model_edge();
        bit    pop, fill, fgo;
        int    n, c;
        word_t w;
        pop = (mocc > 0) && m_ready;
        c = mcred;
        if (issue_in) begin
            if (mcred == 0) movf = 1'b1;
            else c = c - 1;
        end
        if (valid_in) pend.push_back(data_in);
        n    = pend.size();
        fill = valid_in && (n == LANES);
        fgo  = flush_in && (n > 0);
        if (fill || fgo) begin
            w.d = '0;
            for (int k = 0; k < n; k++) w.d[16*k +: 16] = pend[k];
            w.k = 4'((1 << n) - 1);
            w.l = flush_in;
            if (mocc < DEPTH || pop) begin
                sb.push_back(w);
                mocc++;
                if (fgo) c = c + (LANES - n);
            end else
                movf = 1'b1;
            pend.delete();
        end
        if (pop) begin
            mocc--;
            c = c + LANES;
        end
        mcred = (c > CMAX) ? CMAX : c;
    endtask

    task automatic step(input logic iss, input logic v, input logic [15:0] d,
                        input logic fl, input logic rdy);
        issue_in = iss; valid_in = v; data_in = d; flush_in = fl; m_ready = rdy;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic model_reset();
        sb.delete(); pend.delete();
        mocc = 0; mcred = CMAX; movf = 1'b0; inflight = 0;
    endtask

    // monitor: continuous status checks plus scoreboard pop on every handshake
    always @(negedge clk) begin
        word_t w;
        chk("m_valid", 64'(mif.m_valid), 64'(mocc != 0));
        chk("can_issue", 64'(can_issue), 64'(mcred != 0));
        chk("overflow_err", 64'(overflow_err), 64'(movf));
        chk("credits", 64'(dut.r_credits), 64'(mcred));
        if (mif.m_valid && mif.m_ready) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_underrun actual=word required=none t=%0t", $time);
            end else begin
                w = sb.pop_front();
                chk("m_data", mif.m_data, w.d);
                chk("m_mask", 64'(mif.m_mask), 64'(w.k));
                chk("m_last", 64'(mif.m_last), 64'(w.l));
            end
        end
    end

    logic [15:0] vals[4];

    initial begin
        vals[0] = 16'h3F00; vals[1] = 16'h3F3B; vals[2] = 16'h3F62; vals[3] = 16'h3F74;
        #12 rst = 1'b0;
        chk("rst_m_data", mif.m_data, 64'h0);
        chk("rst_m_mask", 64'(mif.m_mask), 64'h0);
        chk("rst_m_last", 64'(mif.m_last), 64'h0);
        chk("rst_cred", 64'(dut.r_credits), 64'(CMAX));
        @(posedge clk); #1;

        // full word
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 1, vals[i], 0, 1);
        chk("w1_valid", 64'(mif.m_valid), 64'h1);
        chk("w1_data", mif.m_data, 64'h3F74_3F62_3F3B_3F00);
        chk("w1_mask", 64'(mif.m_mask), 64'hF);
        chk("w1_last", 64'(mif.m_last), 64'h0);
        step(0, 0, 0, 0, 1);
        chk("w1_cred", 64'(dut.r_credits), 64'd32);

        // partial flush
        step(1, 0, 0, 0, 1); step(1, 0, 0, 0, 1);
        step(0, 1, 16'h3E85, 0, 1); step(0, 1, 16'h3F00, 0, 1);
        step(0, 0, 0, 1, 1);
        chk("fl_data", mif.m_data, 64'h0000_0000_3F00_3E85);
        chk("fl_mask", 64'(mif.m_mask), 64'h3);
        chk("fl_last", 64'(mif.m_last), 64'h1);
        chk("fl_cred", 64'(dut.r_credits), 64'd32);
        step(0, 0, 0, 0, 1);
        chk("fl_cred_pop", 64'(dut.r_credits), 64'd32);

        // fill FIFO with m_ready low
        for (int c = 0; c < 37; c++)
            step(c < 32, c >= 5, 16'($urandom), 0, 0);
        chk("full_can_issue", 64'(can_issue), 64'h0);
        chk("full_occ", 64'(dut.r_cnt), 64'd8);
        chk("full_ovf", 64'(overflow_err), 64'h0);
        step(0, 0, 0, 0, 1);
        chk("pop1_cred", 64'(dut.r_credits), 64'd4);
        chk("pop1_can_issue", 64'(can_issue), 64'h1);

        // refill to full with one partial word (returns 3 credits)
        step(1, 0, 0, 0, 0); step(0, 1, 16'h1234, 0, 0); step(0, 0, 0, 1, 0);
        chk("refull_occ", 64'(dut.r_cnt), 64'd8);
        chk("refull_cred", 64'(dut.r_credits), 64'd6);

        // full FIFO, push and pop in the same cycle
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 16'($urandom), 0, 0);
        step(0, 1, 16'hBEEF, 0, 1);
        chk("pp_occ", 64'(dut.r_cnt), 64'd8);
        chk("pp_ovf", 64'(overflow_err), 64'h0);

        // drain credits, issue past zero, then drop a word into the full FIFO
        for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 16'($urandom), 0, 0);
        chk("drop_ovf", 64'(overflow_err), 64'h1);
        chk("drop_occ", 64'(dut.r_cnt), 64'd8);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
        chk("sticky_ovf", 64'(overflow_err), 64'h1);

        // asynchronous reset with lc=3 and 5 words buffered
        for (int i = 0; i < 3; i++) step(0, 1, 16'($urandom), 0, 0);
        chk("pre_rst_occ", 64'(dut.r_cnt), 64'd5);
        chk("pre_rst_lc", 64'(dut.r_lc), 64'd3);
        #1 rst = 1'b1;
        #1;
        chk("arst_m_valid", 64'(mif.m_valid), 64'h0);
        chk("arst_can_issue", 64'(can_issue), 64'h1);
        chk("arst_cred", 64'(dut.r_credits), 64'd32);
        chk("arst_ovf", 64'(overflow_err), 64'h0);
        model_reset();
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 1, vals[3-i], 0, 1);
        chk("post_rst_mask", 64'(mif.m_mask), 64'hF);
        chk("post_rst_data", mif.m_data, 64'h3F00_3F3B_3F62_3F74);
        step(0, 0, 0, 0, 1);

        // randomized traffic honouring can_issue
        for (int c = 0; c < 400; c++) begin
            logic iss, v;
            iss = (mcred > 0) && ($urandom_range(0, 1) == 1);
            v   = (inflight > 0) && ($urandom_range(0, 2) != 0);
            if (iss) inflight++;
            if (v) inflight--;
            step(iss, v, 16'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
        end
        while (inflight > 0) begin
            inflight--;
            step(0, 1, 16'($urandom), 0, 1);
        end
        step(0, 0, 0, 1, 1);
        for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 1);
        chk("sb_drained", 64'(sb.size()), 64'h0);
        chk("final_occ", 64'(dut.r_cnt), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
